// File: rtl/digit_scan_pkg.sv
// Shared definitions for the four-digit multiplexed display scanner.
//   state_t        : scanner FSM state encoding
//   DIV_DEFAULT    : default clock cycles per digit dwell
//   BLANK_DEFAULT  : default leading blank cycles per dwell
//   NUM_DIGITS     : number of scanned digits
//   NIB_W          : width of one digit code
//   digit_of()     : extracts digit idx from a packed four-digit word
package digit_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BLANKING = 2'd1,
    ST_SHOW     = 2'd2
  } state_t;

  localparam int DIV_DEFAULT   = 50000;
  localparam int BLANK_DEFAULT = 1000;
  localparam int NUM_DIGITS    = 4;
  localparam int NIB_W         = 4;
  localparam int SEL_W         = 2;
  localparam int DATA_W        = NUM_DIGITS * NIB_W;

  function automatic logic [NIB_W-1:0] digit_of(input logic [DATA_W-1:0] word,
                                                input logic [SEL_W-1:0]  idx);
    return word[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_tick_div.sv
// Dwell prescaler: counts 0..DIV-1 while enabled, clears to 0 when disabled.
//   clk, rst_n : system clock, async active-low reset
//   i_en       : count enable; low forces the count back to 0
//   o_count    : current prescaler value
//   o_tc       : high during the last cycle of a dwell (count = DIV-1, enabled)
module tick_div
  import digit_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;
  logic          w_tc;

  assign w_tc = i_en && (r_count == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_en || w_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = w_tc;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scan controller with tear-free double-buffered data.
//   clk, rst_n : system clock, async active-low reset
//   en         : scan enable (level)
//   load       : one-cycle strobe capturing data into the shadow register
//   data       : four 4-bit digit codes, digit k = data[4k+3:4k]
//   sel        : active digit index
//   nib        : code of the active digit
//   blank      : segment drive suppressed
//   frame      : one-cycle pulse in the first cycle after the 3 -> 0 wrap
//
// state       | meaning
// ST_IDLE     | scan halted, blank high, prescaler at 0, sel/nib held
// ST_BLANKING | leading anti-ghost part of a dwell (prescaler < BLANK)
// ST_SHOW     | digit driven (prescaler >= BLANK)
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int BLANK = BLANK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic [SEL_W-1:0]  sel,
  output logic [NIB_W-1:0]  nib,
  output logic              blank,
  output logic              frame
);

  localparam int CW = $clog2(DIV);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [DATA_W-1:0] r_active, w_active_nxt;
  logic [DATA_W-1:0] r_shadow, w_shadow_nxt;
  logic              r_pending, w_pending_nxt;
  logic [NIB_W-1:0]  r_nib;
  logic              r_blank;
  logic              r_frame;
  logic              w_run;
  logic              w_tc;
  logic              w_wrap;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_nxt;

  // The prescaler stays at 0 for the IDLE -> scanning edge, so the first
  // scanning cycle is prescaler 0 and every resumed dwell is a full one.
  assign w_run = en && (r_state != ST_IDLE);

  tick_div #(.DIV(DIV), .CW(CW)) u_tick_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_run),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  assign w_count_nxt = w_tc ? '0 : w_count + 1'b1;
  assign w_wrap      = w_tc && (r_sel == SEL_W'(NUM_DIGITS - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;

    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = (BLANK == 0) ? ST_SHOW : ST_BLANKING;
    end else begin
      w_state_nxt = (int'(w_count_nxt) < BLANK) ? ST_BLANKING : ST_SHOW;
    end

    if (w_tc) begin
      w_sel_nxt = r_sel + 1'b1;
    end

    if (load) begin
      w_shadow_nxt  = data;
      w_pending_nxt = 1'b1;
    end

    // Active only changes on the frame boundary; a load on that very edge
    // bypasses the shadow so it is not delayed by a whole frame.
    if (w_wrap) begin
      if (load) begin
        w_active_nxt  = data;
        w_pending_nxt = 1'b0;
      end else if (r_pending) begin
        w_active_nxt  = r_shadow;
        w_pending_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_nib     <= '0;
      r_blank   <= 1'b1;
      r_frame   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_nib     <= digit_of(w_active_nxt, w_sel_nxt);
      r_blank   <= (w_state_nxt != ST_SHOW);
      r_frame   <= w_wrap;
    end
  end

  assign sel   = r_sel;
  assign nib   = r_nib;
  assign blank = r_blank;
  assign frame = r_frame;

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit dwell; legal range 2..65535.
REQ-002 Parameter BLANK, default 1000: leading blank cycles per dwell; legal range 0..DIV-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scan enable; level-sensitive.
REQ-006 load  input  1  one-cycle strobe; captures data into the shadow register.
REQ-007 data  input  16  four 4-bit digit codes; digit k = data[4k+3:4k].
REQ-008 sel  output  2  active digit index; feeds the downstream 2-to-4 one-hot digit decoder.
REQ-009 nib  output  4  code of the active digit, taken from the active register.
REQ-010 blank  output  1  high = segment drive suppressed (anti-ghosting, idle).
REQ-011 frame  output  1  one-cycle pulse, first cycle of each new frame (sel = 0).

Function
REQ-012 States: IDLE, BLANKING, SHOW; all outputs registered.
REQ-013 Prescaler counts 0..DIV-1 while en = 1; dwell = exactly DIV cycles per digit.
REQ-014 On the edge where the prescaler = DIV-1: prescaler -> 0, sel -> sel+1 mod 4.
REQ-015 BLANKING covers prescaler values 0..BLANK-1, with blank = 1; SHOW covers BLANK..DIV-1, with blank = 0.
REQ-016 BLANK = 0: BLANKING is never entered; blank stays 0 throughout the dwell.
REQ-017 IDLE: blank = 1, prescaler held at 0, sel and nib held.
REQ-018 en falling in any state: IDLE on the next edge; the partial dwell is discarded.
REQ-019 en rising in IDLE: BLANKING (or SHOW if BLANK = 0) on the next edge; scan resumes at the held sel with a full dwell.
REQ-020 load = 1 copies data into the shadow register and sets pending.
REQ-021 A load while pending is set overwrites the shadow register; the last load wins.
REQ-022 Shadow-to-active copy happens only on the 3 -> 0 wrap edge, and only if pending; pending clears on that edge.
REQ-023 load on the same edge as the 3 -> 0 wrap: the new data is copied directly to active and pending stays 0.
REQ-024 A load while in IDLE is held pending until the next wrap.
REQ-025 nib = active[4*sel+3 : 4*sel], registered and updated on the same edge as sel.
REQ-026 frame = 1 in the first cycle after the 3 -> 0 wrap; otherwise 0.

Reset
REQ-027 rst_n low: state IDLE, sel = 0, nib = 0, blank = 1, frame = 0, prescaler = 0, pending = 0, shadow = 0, active = 0.
REQ-028 Reset mid-dwell aborts immediately; the first dwell after release starts at sel = 0.

Structure
REQ-029 Shared package digit_scan_pkg holds: state enumeration, DIV/BLANK defaults, digit count (4), nibble width (4).
REQ-030 Single sub-module tick_div (parameterised prescaler): en in, count value out, terminal-count pulse out.
REQ-031 The FSM, shadow/active registers, pending flag and output muxing live in digit_scan_ctrl.

Verification
REQ-032 All scenarios run with DIV = 8 and BLANK = 2.
REQ-033 Basic scan: reset, load data = 0x4321, en = 1 -> frame pulse at the first wrap, then nib = 1, 2, 3, 4 with sel = 0..3, each held 8 cycles; blank = 1 for the first 2 cycles of each dwell.
REQ-034 Tear-free update: load 0xAAAA during the sel = 1 dwell -> nib keeps old values through sel = 3; 0xA appears from the next sel = 0 with frame = 1.
REQ-035 Collision and overwrite: load 0x1111, then load 0x2222 before the wrap -> 0x2222 active after the wrap; load on the exact wrap edge -> visible immediately at sel = 0.
REQ-036 Enable drop: en = 0 at prescaler = 5, sel = 2 -> next cycle blank = 1 and sel = 2 held; en = 1 after 10 cycles -> full 8-cycle dwell at sel = 2, first 2 cycles blanked.
REQ-037 Async reset: rst_n low mid-SHOW at sel = 3, with no clock edge -> outputs reach reset values immediately; after release with en = 1 -> scan restarts at sel = 0.
REQ-038 BLANK = 0 variant: blank stays 0 throughout the entire scan while en = 1.
